// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter that funnels per-source connect/disconnect events
// into a single shared active-device counter, refusing events that would
// wrap the counter and acknowledging each source once its event is done.
module iot_event_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] req_on,
   input  logic [CNT_W-1:0] count_in,
   output logic             change,
   output logic             on_off,
   output logic [N_REQ-1:0] ack,
   output logic             drop,
   output logic             busy,
   output logic [2:0]       grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        ptr_reg, ptr_next;
   logic [2:0]        grant_reg, grant_next;
   logic              sat_reg, sat_next;
   logic              change_reg, change_next;
   logic              on_off_reg, on_off_next;
   logic [N_REQ-1:0]  ack_reg, ack_next;
   logic              drop_reg, drop_next;
   logic              busy_reg, busy_next;

   // Requests and event types rotated so bit 0 is the source at the pointer
   logic [2*N_REQ-1:0] req_rot, on_rot;
   logic               found;
   logic [2:0]         offset;
   logic               sel_dir;
   logic [3:0]         sel_sum;
   logic [2:0]         sel;
   logic               sel_sat;
   logic [N_REQ-1:0]   grant_hot;

   assign req_rot = {req, req} >> ptr_reg;
   assign on_rot  = {req_on, req_on} >> ptr_reg;

   // One-hot decode of the latched grant, used for the acknowledge
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hot
         assign grant_hot[gi] = (grant_reg == 3'(gi));
      end
   endgenerate

   // Priority search upward from the pointer, wrapping modulo N_REQ
   always_comb begin
      found   = 1'b0;
      offset  = 3'd0;
      sel_dir = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_rot[i]) begin
            found   = 1'b1;
            offset  = 3'(i);
            sel_dir = on_rot[i];
         end
      end
      sel_sum = {1'b0, ptr_reg} + {1'b0, offset};
      if (sel_sum >= 4'(N_REQ))
         sel_sum = sel_sum - 4'(N_REQ);
      sel = sel_sum[2:0];
      // Saturation is judged on the count seen as the grant is taken, so
      // the registered change pulse lands in the very next cycle.
      sel_sat = sel_dir ? (count_in == {CNT_W{1'b1}}) : (count_in == '0);
   end

   // Next-state and next-output logic for the IDLE -> ISSUE -> ACK pass
   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      grant_next  = grant_reg;
      sat_next    = sat_reg;
      change_next = 1'b0;
      on_off_next = on_off_reg;
      ack_next    = '0;
      drop_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next  = ISSUE;
               grant_next  = sel;
               on_off_next = sel_dir;
               sat_next    = sel_sat;
               change_next = !sel_sat;
            end
         end
         ISSUE: begin
            state_next = ACK;
            ack_next   = grant_hot;
            drop_next  = sat_reg;
         end
         ACK: begin
            state_next = IDLE;
            ptr_next   = (grant_reg == 3'(N_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and registered outputs; reset aborts any event in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= 3'd0;
         grant_reg  <= 3'd0;
         sat_reg    <= 1'b0;
         change_reg <= 1'b0;
         on_off_reg <= 1'b0;
         ack_reg    <= '0;
         drop_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         grant_reg  <= grant_next;
         sat_reg    <= sat_next;
         change_reg <= change_next;
         on_off_reg <= on_off_next;
         ack_reg    <= ack_next;
         drop_reg   <= drop_next;
         busy_reg   <= busy_next;
      end
   end

   assign change   = change_reg;
   assign on_off   = on_off_reg;
   assign ack      = ack_reg;
   assign drop     = drop_reg;
   assign busy     = busy_reg;
   assign grant_id = grant_reg;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Bench for iot_event_arbiter: emulates the monitor counter and checks each
// event against a transaction-level model of grant order and saturation.
module tb_iot_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] req_on;
   logic [7:0] count_in;
   logic       change;
   logic       on_off;
   logic [3:0] ack;
   logic       drop;
   logic       busy;
   logic [2:0] grant_id;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor emulation with a preload port for setting up boundary counts
   logic [7:0] mon_cnt;
   logic       load_en = 1'b0;
   logic [7:0] load_val = 8'd0;

   // Transaction-level model state
   int         m_ptr = 0;
   logic [7:0] exp_cnt = 8'd0;

   iot_event_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_on(req_on), .count_in(count_in),
      .change(change), .on_off(on_off), .ack(ack), .drop(drop),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Monitor counter: counts on change, reset by the same rst
   always @(posedge clk) begin
      if (rst)          mon_cnt <= 8'd0;
      else if (load_en) mon_cnt <= load_val;
      else if (change)  mon_cnt <= on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
   end
   assign count_in = mon_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preset(input logic [7:0] v);
      load_en  = 1'b1;
      load_val = v;
      @(posedge clk);
      #1 load_en = 1'b0;
      exp_cnt = v;
   endtask

   // One full event: request, expected pulse, ack, return to idle
   task automatic run_event(input logic [3:0] r, input logic [3:0] o);
      int g;
      logic dir, sat;
      logic [3:0] exp_ack;
      req = r;
      req_on = o;
      g = -1;
      for (int i = 0; i < 4; i++) begin
         if (g < 0 && r[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
      end
      dir = o[g];
      sat = dir ? (exp_cnt == 8'hFF) : (exp_cnt == 8'h00);
      exp_ack = 4'b0001 << g;
      @(posedge clk);
      @(negedge clk);
      check("issue_change", change, !sat);
      check("issue_on_off", on_off, dir);
      check("issue_busy", busy, 1'b1);
      check("issue_grant", grant_id, g);
      check("issue_ack", ack, 4'b0000);
      @(negedge clk);
      if (!sat) exp_cnt = dir ? exp_cnt + 8'd1 : exp_cnt - 8'd1;
      check("ack_vec", ack, exp_ack);
      check("ack_drop", drop, sat);
      check("ack_change", change, 1'b0);
      check("ack_grant", grant_id, g);
      check("ack_count", count_in, exp_cnt);
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_ack", ack, 4'b0000);
      check("idle_drop", drop, 1'b0);
      m_ptr = (g + 1) % 4;
      $display("event req=%b on=%b grant=%0d dir=%0d sat=%0d count=%0d",
               r, o, g, dir, sat, exp_cnt);
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b1111;
      req_on = 4'b1111;
      // Reset holds everything quiet even with all requests raised
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rst_change", change, 1'b0);
         check("rst_ack", ack, 4'b0000);
         check("rst_busy", busy, 1'b0);
         check("rst_grant", grant_id, 3'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      m_ptr = 0;
      exp_cnt = 8'd0;

      // Fairness: all sources requesting, grants rotate 0,1,2,3,0
      for (int k = 0; k < 5; k++) run_event(4'b1111, 4'b1111);

      // Single connect from source 2 at count 5
      preset(8'd5);
      run_event(4'b0100, 4'b0100);

      // Saturation low: disconnect at zero is dropped
      preset(8'd0);
      run_event(4'b0001, 4'b0000);

      // Saturation high on source 3, then a disconnect from source 0
      preset(8'd255);
      run_event(4'b1000, 4'b1000);
      run_event(4'b0001, 4'b0000);

      // Reset during ISSUE aborts the event without an ack
      req = 4'b0010;
      req_on = 4'b0010;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_issue_busy", busy, 1'b1);
      @(negedge clk);
      check("mid_rst_change", change, 1'b0);
      check("mid_rst_on_off", on_off, 1'b0);
      check("mid_rst_ack", ack, 4'b0000);
      check("mid_rst_drop", drop, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_grant", grant_id, 3'd0);
      rst = 1'b0;
      m_ptr = 0;
      exp_cnt = 8'd0;
      run_event(4'b0010, 4'b0010);

      // Randomised events, with occasional boundary presets
      for (int k = 0; k < 60; k++) begin
         int pick;
         pick = $urandom_range(0, 7);
         if (pick == 0)      preset(8'd0);
         else if (pick == 1) preset(8'd255);
         else if (pick == 2) preset(8'($urandom_range(0, 255)));
         run_event(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
